// File: rtl/pixel_write_buffer.sv
// Buffers painter pixel strobes in a small FIFO and streams them, or a full-screen clear, to the VGA adapter.
// A pending clear holds back pixels captured after its request until the clear finishes.
module pixel_write_buffer #(
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int COLOR_BITS = 3,
  parameter int SCR_W      = 160,
  parameter int SCR_H      = 120,
  parameter int DEPTH      = 4
) (
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic [X_BITS-1:0]     paint_x_co,
  input  logic [Y_BITS-1:0]     paint_y_co,
  input  logic [COLOR_BITS-1:0] color,
  input  logic                  print_enable,
  input  logic                  clear_req,
  input  logic [COLOR_BITS-1:0] clear_color,
  input  logic                  vga_ready,
  output logic [X_BITS-1:0]     vga_x,
  output logic [Y_BITS-1:0]     vga_y,
  output logic [COLOR_BITS-1:0] vga_colour,
  output logic                  vga_plot,
  output logic                  busy,
  output logic                  overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = X_BITS + Y_BITS + COLOR_BITS;
  localparam logic [X_BITS:0]     LP_W     = (X_BITS+1)'(SCR_W);
  localparam logic [Y_BITS:0]     LP_H     = (Y_BITS+1)'(SCR_H);
  localparam logic [X_BITS-1:0]   LP_XMAX  = X_BITS'(SCR_W - 1);
  localparam logic [Y_BITS-1:0]   LP_YMAX  = Y_BITS'(SCR_H - 1);
  localparam logic [AW:0]         LP_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;
  state_t r_state, w_state_nxt;

  logic [PW-1:0]         r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_count, r_clr_wait;
  logic                  r_pe_prev, r_clr_pend, r_overflow, r_plot, r_clr_last;
  logic [COLOR_BITS-1:0] r_clr_color, r_clr_act, r_oc;
  logic [X_BITS-1:0]     r_cx, r_ox;
  logic [Y_BITS-1:0]     r_cy, r_oy;

  logic          w_onscreen, w_push, w_empty, w_full, w_out_free, w_fence;
  logic          w_pop, w_push_ok, w_clr_start, w_clr_load, w_clr_end, w_clr_arm;
  logic          w_in_clear, w_busy;
  logic [PW-1:0] w_head;

  assign w_onscreen  = ({1'b0, paint_x_co} < LP_W) && ({1'b0, paint_y_co} < LP_H);
  assign w_push      = print_enable && !r_pe_prev && w_onscreen;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == LP_DEPTH);
  assign w_out_free  = !r_plot || vga_ready;
  // Once every pixel older than the clear request has left the FIFO, stop popping.
  assign w_fence     = r_clr_pend && (r_clr_wait == '0);
  assign w_pop       = !w_in_clear && !w_empty && w_out_free && !w_fence;
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_clr_start = (r_state != S_CLEAR) && w_fence && !r_plot;
  assign w_clr_load  = w_in_clear && w_out_free && !r_clr_last;
  assign w_clr_end   = w_in_clear && r_clr_last && r_plot && vga_ready;
  assign w_clr_arm   = clear_req && (!r_clr_pend || w_clr_start);
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge Clck) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge Clck) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {paint_x_co, paint_y_co, color};
  end

  always_ff @(posedge Clck) begin
    if (!Reset) begin
      r_pe_prev   <= 1'b1;
      r_overflow  <= 1'b0;
      r_clr_pend  <= 1'b0;
      r_clr_wait  <= '0;
      r_clr_color <= '0;
      r_clr_act   <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_clr_last  <= 1'b0;
    end else begin
      r_pe_prev <= print_enable;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (clear_req) r_clr_color <= clear_color;
      if (clear_req)        r_clr_pend <= 1'b1;
      else if (w_clr_start) r_clr_pend <= 1'b0;
      // Count of FIFO entries that must still drain before the clear may begin.
      if (w_clr_arm)                        r_clr_wait <= r_count - (AW+1)'(w_pop);
      else if (w_pop && r_clr_wait != '0)   r_clr_wait <= r_clr_wait - 1'b1;
      if (w_clr_start) begin
        r_cx       <= '0;
        r_cy       <= '0;
        r_clr_last <= 1'b0;
        r_clr_act  <= r_clr_color;
      end else if (w_clr_load) begin
        if (r_cx == LP_XMAX) begin
          r_cx <= '0;
          if (r_cy == LP_YMAX) r_clr_last <= 1'b1;
          else                 r_cy <= r_cy + 1'b1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clck) begin
    if (!Reset) begin
      r_plot <= 1'b0;
      r_ox   <= '0;
      r_oy   <= '0;
      r_oc   <= '0;
    end else if (w_clr_load) begin
      r_plot <= 1'b1;
      r_ox   <= r_cx;
      r_oy   <= r_cy;
      r_oc   <= r_clr_act;
    end else if (w_pop) begin
      r_plot <= 1'b1;
      {r_ox, r_oy, r_oc} <= w_head;
    end else if (r_plot && vga_ready) begin
      r_plot <= 1'b0;
    end
  end

  always_ff @(posedge Clck) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_clr_start)                w_state_nxt = S_CLEAR;
               else if (!w_empty)            w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_clr_start)                w_state_nxt = S_CLEAR;
               else if (w_empty && w_out_free) w_state_nxt = S_IDLE;
      S_CLEAR: if (w_clr_end)                  w_state_nxt = w_empty ? S_IDLE : S_DRAIN;
      default:                                 w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_clear = (r_state == S_CLEAR);
    w_busy     = (r_state != S_IDLE) || !w_empty || r_clr_pend || r_plot;
  end

  assign vga_x      = r_ox;
  assign vga_y      = r_oy;
  assign vga_colour = r_oc;
  assign vga_plot   = r_plot;
  assign busy       = w_busy;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_pixel_write_buffer.sv
// Bench for pixel_write_buffer: directed scenarios plus a random phase, with a queue-based
// reference model of expected pixels checked at every handshake.
module tb_pixel_write_buffer;
  localparam int XB = 8, YB = 7, CB = 3, SW = 160, SH = 120, DP = 4;

  logic          Clck = 1'b0;
  logic          Reset;
  logic [XB-1:0] paint_x_co;
  logic [YB-1:0] paint_y_co;
  logic [CB-1:0] color, clear_color, vga_colour;
  logic          print_enable, clear_req, vga_ready;
  logic [XB-1:0] vga_x;
  logic [YB-1:0] vga_y;
  logic          vga_plot, busy, overflow;

  pixel_write_buffer #(.X_BITS(XB), .Y_BITS(YB), .COLOR_BITS(CB), .SCR_W(SW), .SCR_H(SH),
                       .DEPTH(DP)) dut (
    .Clck(Clck), .Reset(Reset), .paint_x_co(paint_x_co), .paint_y_co(paint_y_co),
    .color(color), .print_enable(print_enable), .clear_req(clear_req),
    .clear_color(clear_color), .vga_ready(vga_ready), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .overflow(overflow));

  always #5 Clck = ~Clck;

  int n_asserts = 0;
  int n_fail    = 0;
  int n_xfer    = 0;
  logic [17:0] exp_q[$];
  logic        exp_ovf  = 1'b0;
  logic        prev_pe  = 1'b1;
  logic        hold_vld = 1'b0;
  logic [17:0] hold_pix = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clck);
    #1;
  endtask

  task automatic strobe(input int x, input int y, input int c);
    paint_x_co = XB'(x); paint_y_co = YB'(y); color = CB'(c);
    print_enable = 1'b1;
    tick();
    print_enable = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i;
    for (i = 0; i < budget && busy !== 1'b0; i++) tick();
    chk(tag, {31'b0, busy}, 32'd0);
  endtask

  // Reference model: inputs are stable from just after each rising edge, so at the
  // falling edge we know exactly what the next rising edge will capture or transfer.
  always @(negedge Clck) begin
    logic push_now;
    if (Reset !== 1'b1) begin
      exp_q.delete();
      prev_pe  = 1'b1;
      exp_ovf  = 1'b0;
      hold_vld = 1'b0;
    end else begin
      if (hold_vld)
        chk("hold_stable", {13'b0, vga_plot, vga_x, vga_y, vga_colour}, {13'b0, 1'b1, hold_pix});
      hold_vld = vga_plot && !vga_ready;
      hold_pix = {vga_x, vga_y, vga_colour};
      push_now = print_enable && !prev_pe && (int'(paint_x_co) < SW) && (int'(paint_y_co) < SH);
      prev_pe  = print_enable;
      // Outstanding = FIFO plus output register; full only when both are occupied.
      if (push_now && exp_q.size() >= DP + 1 && !vga_ready) begin
        exp_ovf  = 1'b1;
        push_now = 1'b0;
      end
      if (vga_plot && vga_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) chk("xfer_unexpected", {14'b0, vga_x, vga_y, vga_colour}, 32'hFFFF_FFFF);
        else begin
          chk("xfer_pix", {14'b0, vga_x, vga_y, vga_colour}, {14'b0, exp_q[0]});
          void'(exp_q.pop_front());
        end
      end
      if (push_now) exp_q.push_back({paint_x_co, paint_y_co, color});
      if (clear_req)
        for (int yy = 0; yy < SH; yy++)
          for (int xx = 0; xx < SW; xx++)
            exp_q.push_back({XB'(xx), YB'(yy), clear_color});
    end
  end

  initial begin
    int base;
    Reset = 1'b0; paint_x_co = '0; paint_y_co = '0; color = '0; print_enable = 1'b0;
    clear_req = 1'b0; clear_color = '0; vga_ready = 1'b0;
    tick(); tick();
    chk("rst_plot", {31'b0, vga_plot}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ovf", {31'b0, overflow}, 0);
    chk("rst_x", {24'b0, vga_x}, 0);
    chk("rst_y", {25'b0, vga_y}, 0);
    chk("rst_c", {29'b0, vga_colour}, 0);
    Reset = 1'b1;
    tick();

    // Single held strobe: one capture, plot one edge after the capture edge.
    base = n_xfer;
    vga_ready = 1'b1;
    paint_x_co = 8'd10; paint_y_co = 7'd20; color = 3'b110; print_enable = 1'b1;
    tick();
    chk("lat_plot_k", {31'b0, vga_plot}, 0);
    tick();
    chk("lat_plot_k1", {31'b0, vga_plot}, 1);
    chk("lat_pix", {14'b0, vga_x, vga_y, vga_colour}, {14'b0, 8'd10, 7'd20, 3'b110});
    tick(); tick();
    print_enable = 1'b0;
    wait_idle(50, "held_idle");
    chk("held_count", n_xfer - base, 1);

    // Off-screen pixel is discarded silently.
    base = n_xfer;
    strobe(160, 5, 2);
    wait_idle(50, "offscr_idle");
    chk("offscr_ovf", {31'b0, overflow}, 0);
    chk("offscr_count", n_xfer - base, 0);

    // Overflow: with ready low, five pixels fit (FIFO + output register), the sixth drops.
    base = n_xfer;
    vga_ready = 1'b0;
    for (int i = 0; i < 6; i++) strobe(i * 7 + 1, i + 2, i);
    chk("ovf_set", {31'b0, overflow}, 1);
    chk("ovf_head", {14'b0, vga_plot, vga_x, vga_y, vga_colour}, {14'b0, 1'b1, 8'd1, 7'd2, 3'd0});
    vga_ready = 1'b1;
    wait_idle(100, "ovf_idle");
    chk("ovf_count", n_xfer - base, 5);
    chk("ovf_sticky", {31'b0, overflow}, 1);
    chk("ovf_model", {31'b0, overflow}, {31'b0, exp_ovf});

    // Ready toggling while draining.
    base = n_xfer;
    vga_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(50 + i, 60 + i, 7 - i);
    for (int i = 0; i < 24; i++) begin
      vga_ready = ~vga_ready;
      tick();
    end
    vga_ready = 1'b1;
    wait_idle(100, "tog_idle");
    chk("tog_count", n_xfer - base, 4);

    // Full clear with a pixel strobed mid-clear; it must follow the last clear pixel.
    base = n_xfer;
    clear_color = 3'b001; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick(); tick();
    chk("clr_first", {14'b0, vga_plot, vga_x, vga_y, vga_colour}, {14'b0, 1'b1, 8'd0, 7'd0, 3'd1});
    for (int i = 0; i < 3000; i++) tick();
    strobe(7, 8, 5);
    wait_idle(25000, "clr_idle");
    chk("clr_count", n_xfer - base, SW * SH + 1);
    chk("clr_q_empty", exp_q.size(), 0);

    // Reset in the middle of a clear, with two pixels queued and the strobe held high.
    clear_color = 3'b010; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 500; i++) tick();
    strobe(20, 30, 4);
    paint_x_co = 8'd21; paint_y_co = 7'd31; color = 3'd3; print_enable = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    chk("mid_rst_plot", {31'b0, vga_plot}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_ovf", {31'b0, overflow}, 0);
    Reset = 1'b1;
    base = n_xfer;
    for (int i = 0; i < 5; i++) tick();
    chk("held_rst_busy", {31'b0, busy}, 0);
    chk("held_rst_plot", {31'b0, vga_plot}, 0);
    chk("held_rst_count", n_xfer - base, 0);
    print_enable = 1'b0;
    tick();

    // Random strobes, coordinates (some off-screen) and ready.
    for (int i = 0; i < 1500; i++) begin
      vga_ready    = 1'($urandom_range(0, 1));
      print_enable = 1'($urandom_range(0, 1));
      paint_x_co   = XB'($urandom_range(0, 175));
      paint_y_co   = YB'($urandom_range(0, 127));
      color        = CB'($urandom_range(0, 7));
      tick();
    end
    print_enable = 1'b0;
    vga_ready = 1'b1;
    wait_idle(200, "rnd_idle");
    chk("rnd_q_empty", exp_q.size(), 0);
    chk("rnd_ovf", {31'b0, overflow}, {31'b0, exp_ovf});

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
